// File: rtl/axi2ahb_pkg.sv
// Shared types and AHB/AXI encodings for the AXI4-Lite to AHB-Lite bridge.
package axi2ahb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRESP = 3'd3,
    ST_RRESP = 3'd4
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] AXI_OKAY    = 2'b00;
  localparam logic [1:0] AXI_SLVERR  = 2'b10;

endpackage

// File: rtl/axi2ahb_wdog.sv
// Data-phase watchdog: loaded with TIMEOUT on entry to DATA, counts down on
// each stalled cycle and flags expiry on the stalled cycle that reaches TIMEOUT.
module axi2ahb_wdog #(
  parameter int TIMEOUT = 256
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Down-counter: clear has priority over load, load over decrement.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Terminal count: the stalled cycle that would take the counter to zero.
  assign o_expire = i_en && (r_cnt == CW'(1));

endmodule

// File: rtl/axi2ahb_lite.sv
// AXI4-Lite slave to AHB-Lite master bridge; one single word transfer in flight.
module axi2ahb_lite
  import axi2ahb_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [AWIDTH-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [DWIDTH/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [AWIDTH-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DWIDTH-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  output logic [AWIDTH-1:0]   haddr,
  output logic [1:0]          htrans,
  output logic                hwrite,
  output logic [2:0]          hsize,
  output logic [2:0]          hburst,
  output logic                hsel,
  output logic [DWIDTH-1:0]   hwdata,
  input  logic [DWIDTH-1:0]   hrdata,
  input  logic                hready,
  input  logic [1:0]          hresp
);

  state_t              r_state;
  state_t              w_next;
  logic                r_last_rd;
  logic                r_is_wr;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [DWIDTH-1:0]   r_rdata;
  logic [1:0]          r_resp;

  logic                w_wr_pend;
  logic                w_rd_pend;
  logic                w_grant_wr;
  logic                w_grant_rd;
  logic                w_strb_ok;
  logic                w_expire;
  logic                w_wd_load;
  logic                w_wd_en;
  logic                w_wd_clr;

  // Requests are masked by reset so the ready outputs read 0 while hresetn is low.
  assign w_wr_pend  = hresetn && awvalid && wvalid;
  assign w_rd_pend  = hresetn && arvalid;
  assign w_grant_wr = (r_state == ST_IDLE) && w_wr_pend && (!w_rd_pend || r_last_rd);
  assign w_grant_rd = (r_state == ST_IDLE) && w_rd_pend && !w_grant_wr;
  assign w_strb_ok  = &wstrb;

  assign w_wd_load = (r_state == ST_ADDR) && hready;
  assign w_wd_en   = (r_state == ST_DATA) && !hready;
  assign w_wd_clr  = (r_state == ST_IDLE);

  axi2ahb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .i_clr    (w_wd_clr),
    .i_load   (w_wd_load),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake/address-phase outputs.
  always_comb begin
    w_next  = r_state;
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    hsel    = 1'b0;
    htrans  = HTRANS_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_wr) begin
          awready = 1'b1;
          wready  = 1'b1;
          // Partial strobes cannot be expressed as a word transfer: reject locally.
          w_next  = w_strb_ok ? ST_ADDR : ST_WRESP;
        end else if (w_grant_rd) begin
          arready = 1'b1;
          w_next  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        if (hready) w_next = ST_DATA;
      end
      ST_DATA: begin
        hsel = 1'b1;
        if (hready || w_expire) w_next = r_is_wr ? ST_WRESP : ST_RRESP;
      end
      ST_WRESP: begin
        bvalid = 1'b1;
        if (bready) w_next = ST_IDLE;
      end
      ST_RRESP: begin
        rvalid = 1'b1;
        if (rready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture registers: request on grant, response at end of data phase or abort.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_last_rd <= 1'b1;
      r_is_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_resp    <= AXI_OKAY;
    end else if (w_grant_wr) begin
      r_last_rd <= 1'b0;
      r_is_wr   <= 1'b1;
      r_addr    <= awaddr;
      r_wdata   <= wdata;
      if (!w_strb_ok) r_resp <= AXI_SLVERR;
    end else if (w_grant_rd) begin
      r_last_rd <= 1'b1;
      r_is_wr   <= 1'b0;
      r_addr    <= araddr;
    end else if (r_state == ST_DATA) begin
      if (hready) begin
        r_resp <= (hresp == HRESP_OKAY) ? AXI_OKAY : AXI_SLVERR;
        if (!r_is_wr) r_rdata <= hrdata;
      end else if (w_expire) begin
        r_resp  <= AXI_SLVERR;
        r_rdata <= '0;
      end
    end
  end

  assign bresp  = r_resp;
  assign rresp  = r_resp;
  assign rdata  = r_rdata;
  assign haddr  = r_addr;
  assign hwrite = r_is_wr;
  assign hwdata = r_wdata;
  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;

endmodule

// File: tb/tb_axi2ahb_lite.sv
// Randomized bench for axi2ahb_lite with a transaction-level reference model
// and a reactive AHB slave backed by a word memory.
module tb_axi2ahb_lite;

  localparam int TMO = 8;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hsel;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: last granted direction (1 = read) and slave memory.
  bit          m_last_rd = 1'b1;
  logic [31:0] mem [logic [31:0]];

  axi2ahb_lite #(
    .AWIDTH  (32),
    .DWIDTH  (32),
    .TIMEOUT (TMO)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .haddr   (haddr),
    .htrans  (htrans),
    .hwrite  (hwrite),
    .hsize   (hsize),
    .hburst  (hburst),
    .hsel    (hsel),
    .hwdata  (hwdata),
    .hrdata  (hrdata),
    .hready  (hready),
    .hresp   (hresp)
  );

  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // One AXI transaction. wv/rv select which channels are presented; the model
  // decides the winner. aw/dw are hready-low cycles in address/data phase
  // (dw >= TMO means the slave never completes), err makes the slave answer ERROR.
  task automatic txn(input bit wv, input bit rv,
                     input logic [31:0] awa, input logic [31:0] wd, input logic [3:0] st,
                     input logic [31:0] ara, input int aw, input int dw, input bit err);
    bit          gw;
    bit          strb_ok;
    bit          to;
    bit          saw;
    bit          in_data;
    bit          d_first;
    int          a_left;
    int          d_left;
    int          vcyc;
    int          exp_lat;
    int          hold;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    logic [31:0] a;
    logic [1:0]  resp0;
    logic [31:0] data0;

    gw        = (wv && rv) ? m_last_rd : wv;
    m_last_rd = !gw;
    a         = gw ? awa : ara;
    strb_ok   = (st == 4'hF);
    to        = (dw >= TMO);
    if (gw && !strb_ok) begin
      exp_lat  = 1;
      exp_resp = 2'b10;
    end else begin
      exp_lat  = to ? 2 + aw + TMO : 3 + aw + dw;
      exp_resp = (to || err) ? 2'b10 : 2'b00;
    end
    exp_rd = to ? 32'h0 : memrd(a);

    @(negedge hclk);
    awaddr  = awa;
    wdata   = wd;
    wstrb   = st;
    awvalid = wv;
    wvalid  = wv;
    araddr  = ara;
    arvalid = rv;
    hready  = 1'b1;
    hresp   = 2'b00;
    #1;
    check_eq("grant_aw", 32'(awready), 32'(gw));
    check_eq("grant_w",  32'(wready),  32'(gw));
    check_eq("grant_ar", 32'(arready), 32'(!gw));
    @(posedge hclk);

    saw     = 1'b0;
    in_data = 1'b0;
    d_first = 1'b1;
    a_left  = aw;
    d_left  = dw;
    vcyc    = -1;
    for (int cyc = 1; cyc < 80 && vcyc < 0; cyc++) begin
      @(negedge hclk);
      if (gw) begin
        awvalid = 1'b0;
        wvalid  = 1'b0;
      end else begin
        arvalid = 1'b0;
      end
      hready = 1'b1;
      hresp  = 2'b00;
      hrdata = $urandom;
      if (bvalid || rvalid) begin
        vcyc = cyc;
      end else if (in_data) begin
        if (d_first) begin
          check_eq("data_htrans", 32'(htrans), 32'h0);
          check_eq("data_hsel",   32'(hsel),   32'h1);
          if (gw) check_eq("hwdata", hwdata, wd);
          d_first = 1'b0;
        end
        if (d_left > 0) begin
          hready = 1'b0;
          d_left--;
        end else begin
          hrdata = memrd(a);
          hresp  = err ? 2'($urandom_range(1, 3)) : 2'b00;
        end
      end else if (htrans == 2'b10) begin
        if (!saw) begin
          check_eq("haddr",  haddr,         a);
          check_eq("hwrite", 32'(hwrite),   32'(gw));
          check_eq("hsel",   32'(hsel),     32'h1);
          check_eq("hsize",  32'(hsize),    32'h2);
          check_eq("hburst", 32'(hburst),   32'h0);
          saw = 1'b1;
        end
        if (a_left > 0) begin
          hready = 1'b0;
          a_left--;
        end else begin
          in_data = 1'b1;
        end
      end
      #1;
      if (wv && rv) begin
        if (gw) check_eq("loser_arready", 32'(arready), 32'h0);
        else    check_eq("loser_awready", 32'(awready), 32'h0);
      end
    end
    hready = 1'b1;
    hresp  = 2'b00;

    if (gw && strb_ok && !err && !to) mem[a] = wd;

    check_eq("nonseq_seen", 32'(saw), 32'(!(gw && !strb_ok)));
    check_eq("latency", 32'(vcyc), 32'(exp_lat));
    check_eq("bvalid", 32'(bvalid), 32'(gw));
    check_eq("rvalid", 32'(rvalid), 32'(!gw));
    resp0 = gw ? bresp : rresp;
    data0 = rdata;
    check_eq(gw ? "bresp" : "rresp", 32'(resp0), 32'(exp_resp));
    if (!gw) check_eq("rdata", rdata, exp_rd);

    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      @(negedge hclk);
      check_eq("valid_hold", 32'(gw ? bvalid : rvalid), 32'h1);
      check_eq("resp_hold",  32'(gw ? bresp : rresp), 32'(resp0));
      if (!gw) check_eq("rdata_hold", rdata, data0);
    end
    bready = gw;
    rready = !gw;
    @(negedge hclk);
    check_eq("valid_drop", 32'(bvalid | rvalid), 32'h0);
    bready  = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
  endtask

  bit          r_wv;
  bit          r_rv;
  int          r_k;
  logic [31:0] r_awa;
  logic [31:0] r_ara;
  logic [3:0]  r_st;
  int          r_aw;
  int          r_dw;
  bit          r_err;

  initial begin
    hresetn = 1'b0;
    awaddr  = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready  = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    hrdata  = '0; hready = 1'b1; hresp = 2'b00;

    #12;
    check_eq("rst_bvalid", 32'(bvalid), 32'h0);
    check_eq("rst_hsel",   32'(hsel),   32'h0);
    check_eq("rst_htrans", 32'(htrans), 32'h0);
    check_eq("rst_hsize",  32'(hsize),  32'h2);
    check_eq("rst_haddr",  haddr,       32'h0);
    @(negedge hclk);
    hresetn = 1'b1;

    // Conflict from reset goes to the write, the next conflict to the read.
    mem[32'h104] = 32'h12345678;
    txn(1, 1, 32'h180, 32'hA5A5A5A5, 4'hF, 32'h104, 0, 0, 0);
    txn(1, 1, 32'h184, 32'h5A5A5A5A, 4'hF, 32'h180, 0, 0, 0);
    // Minimum-latency write, stretched read, partial strobe, error, timeout.
    txn(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 0);
    txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h104, 0, 3, 0);
    txn(1, 0, 32'h108, 32'h11112222, 4'h3, 32'h0, 0, 0, 0);
    txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h100, 1, 1, 1);
    txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h104, 0, 100, 0);

    // Reset in the data phase discards the write with no response.
    @(negedge hclk);
    awaddr = 32'h200; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; hready = 1'b1;
    @(negedge hclk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge hclk);
    hready = 1'b0;
    #1;
    check_eq("pre_rst_hsel", 32'(hsel), 32'h1);
    #1;
    hresetn = 1'b0;
    #1;
    check_eq("mid_rst_hsel",   32'(hsel),   32'h0);
    check_eq("mid_rst_htrans", 32'(htrans), 32'h0);
    check_eq("mid_rst_hwrite", 32'(hwrite), 32'h0);
    check_eq("mid_rst_haddr",  haddr,       32'h0);
    check_eq("mid_rst_hwdata", hwdata,      32'h0);
    check_eq("mid_rst_rdata",  rdata,       32'h0);
    check_eq("mid_rst_bresp",  32'(bresp),  32'h0);
    check_eq("mid_rst_valid",  32'(bvalid | rvalid), 32'h0);
    check_eq("mid_rst_ready",  32'(awready | wready | arready), 32'h0);
    @(negedge hclk);
    hresetn   = 1'b1;
    hready    = 1'b1;
    m_last_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      check_eq("post_rst_bvalid", 32'(bvalid), 32'h0);
    end

    for (int i = 0; i < 40; i++) begin
      r_k   = int'($urandom_range(0, 3));
      r_wv  = (r_k != 1);
      r_rv  = (r_k != 0);
      r_awa = 32'h100 + 32'(4 * $urandom_range(0, 7));
      r_ara = 32'h100 + 32'(4 * $urandom_range(0, 7));
      r_st  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      r_aw  = int'($urandom_range(0, 2));
      r_dw  = ($urandom_range(0, 9) == 0) ? TMO + 2 : int'($urandom_range(0, 3));
      r_err = ($urandom_range(0, 7) == 0);
      txn(r_wv, r_rv, r_awa, $urandom, r_st, r_ara, r_aw, r_dw, r_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi2ahb_lite.md
# axi2ahb_lite

AXI4-Lite slave to AHB-Lite master bridge, placed directly upstream of the AHB-to-Wishbone bridge in the RISC-V peripheral path. It converts each AXI4-Lite read or write into one AHB single transfer (NONSEQ, HBURST=SINGLE, word size) and returns the AHB response on the AXI B or R channel. One transaction is in flight at a time. A watchdog aborts transfers whose downstream slave never raises hready.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width; wstrb width is DWIDTH/8
- TIMEOUT, 256, maximum data-phase wait cycles before abort (≥2)

- hclk  in  1  clock; all logic on rising edge
- hresetn  in  1  asynchronous, active-low reset
- awaddr/awvalid/awready  in/in/out  AWIDTH/1/1  AXI write address
- wdata/wstrb/wvalid/wready  in/in/in/out  DWIDTH/DWIDTH/8/1/1  AXI write data
- bresp/bvalid/bready  out/out/in  2/1/1  AXI write response
- araddr/arvalid/arready  in/in/out  AWIDTH/1/1  AXI read address
- rdata/rresp/rvalid/rready  out/out/out/in  DWIDTH/2/1/1  AXI read data
- haddr/htrans/hwrite/hsize/hburst/hsel  out  AWIDTH/2/1/3/3/1  AHB address-phase controls
- hwdata  out  DWIDTH  AHB write data
- hrdata  in  DWIDTH  AHB read data
- hready  in  1  transfer complete from downstream bridge
- hresp  in  2  00 OKAY, 01 ERROR, 10/11 treated as error

## Operation
- States: IDLE, ADDR, DATA, WRESP, RRESP.
- IDLE: a write is pending when awvalid & wvalid are both high; a read is pending when arvalid is high. If both are pending, grant the type opposite to the last grant. The last-grant flag resets to "read", so the first conflict goes to the write.
- Write grant: awready and wready pulse high for exactly one cycle together. awaddr and wdata are latched.
  - If wstrb != all-ones, no AHB transfer runs; go to WRESP with bresp=10 (SLVERR).
  - Otherwise go to ADDR.
- Read grant: arready pulses one cycle, araddr is latched, go to ADDR.
- ADDR: drive hsel=1, htrans=10, haddr=latched address, hwrite=type, hsize=010, hburst=000. Hold until hready=1 is sampled, then go to DATA.
- DATA: drive htrans=00 and keep hsel=1. For writes, hwdata=latched wdata. Wait for hready=1, then capture hresp and, for reads, hrdata.
  - hresp=00 gives resp 00; any other hresp gives resp 10.
  - Then go to WRESP or RRESP and drop hsel.
- Watchdog: counts DATA cycles with hready=0. On reaching TIMEOUT, drop hsel, force resp=10 and rdata=0, and go to the response state.
- WRESP: bvalid=1 until bready is sampled high, then IDLE. RRESP behaves the same with rvalid/rready.
- Ready signals are never high outside the IDLE grant cycle, so no new transaction is accepted while one is outstanding.

## Timing
- Reset values (asynchronous):
  - awready=wready=arready=bvalid=rvalid=hsel=hwrite=0
  - bresp=rresp=00, htrans=00, hsize=010, hburst=000
  - haddr, hwdata, rdata = 0
  - state=IDLE, watchdog=0
- Minimum latency with hready always 1 and the accept handshake on cycle 0: ADDR on cycle 1, DATA on cycle 2, bvalid/rvalid on cycle 3.
- bresp/rresp/rdata are stable for as long as valid is high. Valid can drop no earlier than the cycle after ready is sampled high.
- Back-to-back: a new grant can occur on the cycle after the B/R handshake.
- Reset asserted mid-transaction: all outputs take their reset values immediately. The pending transaction is discarded and no B/R response is issued.
- An hready=0 in ADDR stretches ADDR; the watchdog does not run in ADDR.
- The watchdog clears on entry to DATA.

## Structure
- Package axi2ahb_pkg holds:
  - the state enum
  - HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE
  - HRESP_OKAY/ERROR, AXI_OKAY/SLVERR
- Sub-module axi2ahb_wdog: loadable down-counter with clear, enable and expire outputs, parameterised by TIMEOUT.
- The top level contains the FSM, the arbiter flag and the capture registers.

## Test plan
- Write awaddr=0x100, wdata=0xDEADBEEF, wstrb=F, hready=1 → htrans=10/haddr=0x100/hwrite=1 on cycle 1, hwdata=0xDEADBEEF on cycle 2, bvalid on cycle 3 with bresp=00.
- Read araddr=0x104, hrdata=0x12345678, hready low 3 cycles in DATA → rvalid 3 cycles later than minimum, rdata=0x12345678, rresp=00.
- awvalid+wvalid+arvalid together from reset → write granted first; next conflict → read granted.
- wstrb=3 → no htrans=10 ever driven; bvalid with bresp=10.
- hresp=01 in DATA → rresp=10 on read. With hready stuck 0 and TIMEOUT=8 → abort after 8 DATA cycles, rresp=10, rdata=0.
- hresetn low during DATA with bready=0 → all outputs at reset values, and no bvalid after reset release.
